sdram_bus_arbiter: RTL
======================

Name: sdram_bus_arbiter

Overview:
- Owns the single SDRAM command/address/bank bus and shares it between the read engine, the write engine and the periodic auto-refresh.
- Grants one engine at a time by asserting that engine's enable, and muxes the granted engine's command/address/bank onto the SDRAM pins.
- Runs the refresh interval timer and raises auto_refresh to both engines.
- Once the granted engine parks, it drives PRECHARGE-all and AUTO REFRESH itself, then resumes arbitration.

Parameters:
REFRESH_INTERVAL, 780, clk cycles between refresh requests (7.8 us at 100 MHz)
T_RP, 2, NOP cycles after PRECHARGE-all before AUTO REFRESH
T_RFC, 7, NOP cycles after AUTO REFRESH before bus release
CMD_NOP, 3'b111, {RAS,CAS,WE} encoding for NOP
CMD_PRE, 3'b010, PRECHARGE encoding
CMD_AR, 3'b001, AUTO REFRESH encoding

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
rd_request  in  1  application wants reads
wr_request  in  1  application wants writes
rd_idle  in  1  read engine parked (IDLE/WAIT, delay 0)
wr_idle  in  1  write engine parked
rd_command  in  3  read engine command
rd_address  in  12  read engine address
rd_bank  in  2  read engine bank
wr_command  in  3  write engine command
wr_address  in  12  write engine address
wr_bank  in  2  write engine bank
rd_enable  out  1  grant to read engine
wr_enable  out  1  grant to write engine
auto_refresh  out  1  refresh pending; both engines must terminate and park
sdram_command  out  3  command to SDRAM
sdram_address  out  12  address to SDRAM
sdram_bank  out  2  bank to SDRAM
refresh_busy  out  1  arbiter owns bus for refresh
refresh_overrun  out  1  one-cycle pulse when the interval expires while a refresh is still pending

Behaviour:
- Reset: rst low asynchronously forces state IDLE and all outputs to these values: rd_enable=0, wr_enable=0, auto_refresh=0, refresh_busy=0, refresh_overrun=0, sdram_command=CMD_NOP, sdram_address=0, sdram_bank=0. Refresh counter reloads to REFRESH_INTERVAL-1; last_grant=WRITE, so read wins the first tie. Reset mid-refresh aborts it with no special recovery.
- Refresh timer: decrements every cycle in all states. At 0 it reloads, sets refresh_pending and pulses refresh_overrun if refresh_pending is already set. auto_refresh = refresh_pending (registered).
- Bus mux: combinational, zero added latency, so engine CAS timing is preserved.
  - READ state: sdram_* = rd_*.
  - WRITE state: sdram_* = wr_*.
  - Refresh states: arbiter-registered values.
  - Otherwise: NOP / 0 / 0.
- State machine:
  - IDLE:
    - If refresh_pending and rd_idle and wr_idle -> PRE.
    - Else if refresh_pending -> stay.
    - Else if rd_request and wr_request -> grant opposite of last_grant.
    - Else if rd_request -> READ; else if wr_request -> WRITE.
    - Granting sets the enable and updates last_grant on the same edge.
  - READ: rd_enable=1.
    - If refresh_pending and rd_idle -> PRE, with rd_enable held so the engine stays in WAIT and keeps its FIFO.
    - Else if ~rd_request and rd_idle -> IDLE, with rd_enable=0.
    - rd_request dropping while the engine is busy: stay until rd_idle.
  - WRITE: mirror of READ using wr_*.
  - PRE: one cycle of CMD_PRE, sdram_address[10]=1 (all banks), refresh_busy=1; load wait counter with T_RP -> PRE_WAIT.
  - PRE_WAIT: NOP until counter reaches 0 -> AR.
  - AR: one cycle of CMD_AR; load T_RFC -> AR_WAIT.
  - AR_WAIT: NOP until 0, then clear refresh_pending and refresh_busy.
    - Return to the prior grant state (READ/WRITE) if its request is still high.
    - Otherwise return to IDLE with enable dropped.
- No preemption of a granted engine except by refresh; fairness comes only from round-robin at IDLE ties.
- Both enables are never high together. Exactly one source drives the bus in any cycle.
- Timer expiry and clear of refresh_pending in the same cycle: the set wins; the new refresh stays pending.

Test Plan:
1. Reset release, no requests, REFRESH_INTERVAL=20 -> auto_refresh rises at cycle 20; CMD_PRE with addr[10]=1 at cycle 21; CMD_AR at cycle 24 (T_RP=2); refresh_busy low and auto_refresh low after cycle 32.
2. rd_request=1 alone, rd_command=3'b101 -> rd_enable next cycle; sdram_command=3'b101 in the same cycle as rd_command changes; wr_enable stays 0.
3. rd_request and wr_request both high from reset, each dropped after its engine goes idle -> grant order READ, WRITE, READ; never both enables high.
4. Refresh expires during a read burst (rd_idle=0 for 5 cycles) -> auto_refresh=1, no PRE until rd_idle=1; then PRE/AR sequence; rd_enable held throughout; bus returns to the read engine afterward.
5. wr_idle held 0 across two intervals -> refresh_overrun pulses exactly once; a single AR is issued when wr_idle rises.
6. Assert rst low during AR_WAIT -> sdram_command=CMD_NOP and all enables 0 immediately, before the next edge; after release, first refresh request comes REFRESH_INTERVAL cycles later.

Source files
------------

// File: rtl/sdram_bus_arbiter.sv
// rtl/sdram_bus_arbiter.sv - SDRAM command bus arbiter with auto-refresh sequencing
//
// Shares one SDRAM command/address/bank bus between a read engine and a
// write engine. When the refresh interval expires, the arbiter waits for the
// owning engine to park, then issues PRECHARGE-all and AUTO REFRESH itself.
// T_RP and T_RFC are expected to be at least 1.

module sdram_bus_arbiter #(
  parameter int         REFRESH_INTERVAL = 780,
  parameter int         T_RP             = 2,
  parameter int         T_RFC            = 7,
  parameter logic [2:0] CMD_NOP          = 3'b111,
  parameter logic [2:0] CMD_PRE          = 3'b010,
  parameter logic [2:0] CMD_AR           = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_request,
  input  logic        wr_request,
  input  logic        rd_idle,
  input  logic        wr_idle,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_address,
  input  logic [1:0]  rd_bank,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_address,
  input  logic [1:0]  wr_bank,
  output logic        rd_enable,
  output logic        wr_enable,
  output logic        auto_refresh,
  output logic [2:0]  sdram_command,
  output logic [11:0] sdram_address,
  output logic [1:0]  sdram_bank,
  output logic        refresh_busy,
  output logic        refresh_overrun
);

  // Refresh counter holds 0..REFRESH_INTERVAL-1.
  localparam int TW       = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  // Wait counter holds 0..max(T_RP,T_RFC)-1.
  localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WW       = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  localparam logic [TW-1:0] REFRESH_RELOAD = TW'(REFRESH_INTERVAL - 1);
  // Wait counters count down to zero inclusive, so load one less than the NOP count.
  localparam logic [WW-1:0] RP_LOAD        = WW'((T_RP  > 0) ? T_RP  - 1 : 0);
  localparam logic [WW-1:0] RFC_LOAD       = WW'((T_RFC > 0) ? T_RFC - 1 : 0);
  // A10 high selects all banks for PRECHARGE.
  localparam logic [11:0]   PRE_ALL_ADDR   = 12'h400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_AR,
    ST_AR_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_wr_q, last_grant_wr_d;
  logic [TW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic            refresh_pending_q, refresh_pending_d;
  logic            refresh_overrun_q, refresh_overrun_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            rd_enable_q, rd_enable_d;
  logic            wr_enable_q, wr_enable_d;

  logic            refresh_expire;
  logic            refresh_clear;

  // State and datapath registers; reset parks everything and reloads the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      last_grant_wr_q   <= 1'b1;
      refresh_cnt_q     <= REFRESH_RELOAD;
      refresh_pending_q <= 1'b0;
      refresh_overrun_q <= 1'b0;
      wait_cnt_q        <= '0;
      rd_enable_q       <= 1'b0;
      wr_enable_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_wr_q   <= last_grant_wr_d;
      refresh_cnt_q     <= refresh_cnt_d;
      refresh_pending_q <= refresh_pending_d;
      refresh_overrun_q <= refresh_overrun_d;
      wait_cnt_q        <= wait_cnt_d;
      rd_enable_q       <= rd_enable_d;
      wr_enable_q       <= wr_enable_d;
    end
  end

  // Free-running refresh interval timer; a new expiry beats a same-cycle clear.
  always_comb begin
    refresh_expire    = (refresh_cnt_q == '0);
    refresh_cnt_d     = refresh_expire ? REFRESH_RELOAD : (refresh_cnt_q - TW'(1));
    refresh_pending_d = refresh_expire | (refresh_pending_q & ~refresh_clear);
    refresh_overrun_d = refresh_expire & refresh_pending_q;
  end

  // Grant and refresh sequencing; enables stay held through refresh so the engine keeps its context.
  always_comb begin
    state_d         = state_q;
    last_grant_wr_d = last_grant_wr_q;
    wait_cnt_d      = wait_cnt_q;
    rd_enable_d     = rd_enable_q;
    wr_enable_d     = wr_enable_q;
    refresh_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (refresh_pending_q) begin
          if (rd_idle && wr_idle) begin
            state_d = ST_PRE;
          end
        end else if (rd_request && wr_request) begin
          if (last_grant_wr_q) begin
            state_d         = ST_READ;
            rd_enable_d     = 1'b1;
            last_grant_wr_d = 1'b0;
          end else begin
            state_d         = ST_WRITE;
            wr_enable_d     = 1'b1;
            last_grant_wr_d = 1'b1;
          end
        end else if (rd_request) begin
          state_d         = ST_READ;
          rd_enable_d     = 1'b1;
          last_grant_wr_d = 1'b0;
        end else if (wr_request) begin
          state_d         = ST_WRITE;
          wr_enable_d     = 1'b1;
          last_grant_wr_d = 1'b1;
        end
      end

      ST_READ: begin
        if (refresh_pending_q && rd_idle) begin
          state_d = ST_PRE;
        end else if (!rd_request && rd_idle) begin
          state_d     = ST_IDLE;
          rd_enable_d = 1'b0;
        end
      end

      ST_WRITE: begin
        if (refresh_pending_q && wr_idle) begin
          state_d = ST_PRE;
        end else if (!wr_request && wr_idle) begin
          state_d     = ST_IDLE;
          wr_enable_d = 1'b0;
        end
      end

      ST_PRE: begin
        state_d    = ST_PRE_WAIT;
        wait_cnt_d = RP_LOAD;
      end

      ST_PRE_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_AR;
        end else begin
          wait_cnt_d = wait_cnt_q - WW'(1);
        end
      end

      ST_AR: begin
        state_d    = ST_AR_WAIT;
        wait_cnt_d = RFC_LOAD;
      end

      ST_AR_WAIT: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WW'(1);
        end else begin
          refresh_clear = 1'b1;
          if (rd_enable_q && rd_request) begin
            state_d = ST_READ;
          end else if (wr_enable_q && wr_request) begin
            state_d = ST_WRITE;
          end else begin
            state_d     = ST_IDLE;
            rd_enable_d = 1'b0;
            wr_enable_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rd_enable_d = 1'b0;
        wr_enable_d = 1'b0;
      end
    endcase
  end

  // Zero-latency bus mux: the granted engine drives the pins directly, refresh states drive decoded commands.
  always_comb begin
    sdram_command = CMD_NOP;
    sdram_address = '0;
    sdram_bank    = '0;
    refresh_busy  = 1'b0;

    case (state_q)
      ST_READ: begin
        sdram_command = rd_command;
        sdram_address = rd_address;
        sdram_bank    = rd_bank;
      end
      ST_WRITE: begin
        sdram_command = wr_command;
        sdram_address = wr_address;
        sdram_bank    = wr_bank;
      end
      ST_PRE: begin
        sdram_command = CMD_PRE;
        sdram_address = PRE_ALL_ADDR;
        refresh_busy  = 1'b1;
      end
      ST_AR: begin
        sdram_command = CMD_AR;
        refresh_busy  = 1'b1;
      end
      ST_PRE_WAIT, ST_AR_WAIT: begin
        refresh_busy  = 1'b1;
      end
      default: begin
        sdram_command = CMD_NOP;
      end
    endcase
  end

  assign rd_enable       = rd_enable_q;
  assign wr_enable       = wr_enable_q;
  assign auto_refresh    = refresh_pending_q;
  assign refresh_overrun = refresh_overrun_q;

endmodule
